// File: rtl/loop_recorder_sequencer_if.sv
// rtl/loop_recorder_sequencer_if.sv - key-pattern RAM port shared by the loop sequencer
interface loop_recorder_sequencer_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_wdata;
   logic              ram_wren;
   logic [3:0]        ram_rdata;

   modport master (
      output ram_addr,
      output ram_wdata,
      output ram_wren,
      input  ram_rdata
   );

   modport slave (
      input  ram_addr,
      input  ram_wdata,
      input  ram_wren,
      output ram_rdata
   );
endinterface

// File: rtl/loop_recorder_sequencer.sv
// rtl/loop_recorder_sequencer.sv - record/playback sequencer over a shared key-pattern RAM
module loop_recorder_sequencer #(
   parameter int TICK_DIV  = 50000000,
   parameter int NUM_SLOTS = 29,
   parameter int ADDR_W    = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  go,
   input  logic [3:0]            keys,
   loop_recorder_sequencer_if.master ram,
   output logic [3:0]            play_keys,
   output logic [1:0]            mode,
   output logic [ADDR_W-1:0]     rec_len
);
   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  LOAD_CNT  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] SLOT_LAST = ADDR_W'(NUM_SLOTS - 1);
   localparam logic [ADDR_W-1:0] SLOT_FULL = ADDR_W'(NUM_SLOTS);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   typedef enum logic [2:0] {
      IDLE, ARM_REC, RECORD, REC_STOP, READY, ARM_PLAY, PLAY, PLAY_STOP
   } state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  tick_cnt;
   logic [ADDR_W-1:0] slot;
   logic [ADDR_W-1:0] rec_len_next;
   logic [3:0]        play_reg;
   logic              active, tick, entering;

   assign active   = (state == RECORD) || (state == PLAY);
   assign tick     = active && (tick_cnt == TICK_LAST);
   assign entering = ((state_next == RECORD) && (state != RECORD)) ||
                     ((state_next == PLAY)   && (state != PLAY));

   always_comb begin
      state_next   = state;
      rec_len_next = rec_len;
      mode         = 2'b00;
      case (state)
         IDLE:     if (!go) state_next = ARM_REC;
         ARM_REC:  if (go) state_next = RECORD;
         RECORD: begin
            mode = 2'b01;
            if (tick && (slot == SLOT_LAST)) begin
               state_next   = READY;
               rec_len_next = SLOT_FULL;
            end else if (!go) begin
               // a slot whose write lands in this same cycle counts as complete
               state_next   = REC_STOP;
               rec_len_next = tick ? (slot + ONE) : slot;
            end
         end
         REC_STOP: if (go) state_next = (rec_len != '0) ? READY : IDLE;
         READY: begin
            mode = 2'b11;
            if (!go) state_next = ARM_PLAY;
         end
         ARM_PLAY: begin
            mode = 2'b11;
            if (go) state_next = PLAY;
         end
         PLAY: begin
            mode = 2'b10;
            if (tick && (slot == (rec_len - ONE))) state_next = IDLE;
            else if (!go)                          state_next = PLAY_STOP;
         end
         PLAY_STOP: if (go) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         slot     <= '0;
         rec_len  <= '0;
         play_reg <= '0;
      end else begin
         state   <= state_next;
         rec_len <= rec_len_next;
         if (entering) begin
            tick_cnt <= '0;
            slot     <= '0;
         end else if (active) begin
            tick_cnt <= tick ? '0 : (tick_cnt + LOAD_CNT);
            if (tick) slot <= slot + ONE;
         end else begin
            tick_cnt <= '0;
         end
         // read data for the current slot arrives one cycle after the address
         if (state != PLAY)               play_reg <= '0;
         else if (tick_cnt == LOAD_CNT)   play_reg <= ram.ram_rdata;
      end
   end

   assign ram.ram_addr  = slot;
   assign ram.ram_wdata = keys;
   assign ram.ram_wren  = reset && (state == RECORD) && tick;
   assign play_keys     = (state == PLAY) ? play_reg : 4'h0;
endmodule
